// File: rtl/csr_file.sv
// Machine-mode CSR file: mstatus/mie/mtvec/mscratch/mepc/mcause, 64-bit cycle and
// instret counters with user read-only aliases, mhartid, trap entry and mret.
module csr_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0000_0000,
  parameter bit          COUNTERS_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  op_i,
  input  logic [11:0] addr_i,
  input  logic [31:0] wd_i,
  input  logic [4:0]  zimm_i,
  input  logic [31:0] pc_i,
  input  logic        trap_i,
  input  logic [31:0] mcause_i,
  input  logic        mret_i,
  input  logic        instret_i,
  output logic [31:0] rd_o,
  output logic        illegal_o,
  output logic [31:0] mie_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mcause_o,
  output logic        mstatus_mie_o
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] MIE_MASK  = 32'h0000_0888;
  localparam logic [31:0] ALIGN4    = 32'hFFFF_FFFC;
  localparam logic [31:0] MTVEC_RST = MTVEC_RESET & ALIGN4;

  // State
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  // Access decode
  logic        op_active;
  logic        wr_attempt;
  logic        addr_impl;
  logic        addr_ro;
  logic        illegal;
  logic        write_en;
  logic [31:0] operand;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic [31:0] mstatus_rd;

  // MPP is hardwired to machine mode; only MIE and MPIE are stored.
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};

  assign op_active  = (op_i[1:0] != 2'b00);
  assign operand    = op_i[2] ? {27'b0, zimm_i} : wd_i;
  // Set/clear with a zero operand is a pure read and never counts as a write.
  assign wr_attempt = op_active && ((op_i[1:0] == 2'b01) || (operand != 32'h0));

  always_comb begin
    old_val   = 32'h0;
    addr_impl = 1'b0;
    addr_ro   = 1'b0;
    case (addr_i)
      A_MSTATUS: begin
        addr_impl = 1'b1;
        old_val   = mstatus_rd;
      end
      A_MIE: begin
        addr_impl = 1'b1;
        old_val   = mie_q;
      end
      A_MTVEC: begin
        addr_impl = 1'b1;
        old_val   = mtvec_q;
      end
      A_MSCRATCH: begin
        addr_impl = 1'b1;
        old_val   = mscratch_q;
      end
      A_MEPC: begin
        addr_impl = 1'b1;
        old_val   = mepc_q;
      end
      A_MCAUSE: begin
        addr_impl = 1'b1;
        old_val   = mcause_q;
      end
      A_MCYCLE: begin
        addr_impl = COUNTERS_EN;
        old_val   = COUNTERS_EN ? mcycle_q[31:0] : 32'h0;
      end
      A_MCYCLEH: begin
        addr_impl = COUNTERS_EN;
        old_val   = COUNTERS_EN ? mcycle_q[63:32] : 32'h0;
      end
      A_MINSTRET: begin
        addr_impl = COUNTERS_EN;
        old_val   = COUNTERS_EN ? minstret_q[31:0] : 32'h0;
      end
      A_MINSTRETH: begin
        addr_impl = COUNTERS_EN;
        old_val   = COUNTERS_EN ? minstret_q[63:32] : 32'h0;
      end
      A_CYCLE: begin
        addr_impl = COUNTERS_EN;
        addr_ro   = 1'b1;
        old_val   = COUNTERS_EN ? mcycle_q[31:0] : 32'h0;
      end
      A_CYCLEH: begin
        addr_impl = COUNTERS_EN;
        addr_ro   = 1'b1;
        old_val   = COUNTERS_EN ? mcycle_q[63:32] : 32'h0;
      end
      A_INSTRET: begin
        addr_impl = COUNTERS_EN;
        addr_ro   = 1'b1;
        old_val   = COUNTERS_EN ? minstret_q[31:0] : 32'h0;
      end
      A_INSTRETH: begin
        addr_impl = COUNTERS_EN;
        addr_ro   = 1'b1;
        old_val   = COUNTERS_EN ? minstret_q[63:32] : 32'h0;
      end
      A_MHARTID: begin
        addr_impl = 1'b1;
        addr_ro   = 1'b1;
        old_val   = HART_ID;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op_i[1:0])
      2'b01:   new_val = operand;
      2'b10:   new_val = old_val | operand;
      2'b11:   new_val = old_val & ~operand;
      default: new_val = old_val;
    endcase
  end

  assign illegal  = op_active && (!addr_impl || (addr_ro && wr_attempt));
  assign write_en = wr_attempt && !illegal;

  // Next state: counters and CSR writes first, then mret and trap override.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mcycle_d       = mcycle_q + 64'd1;
    minstret_d     = instret_i ? (minstret_q + 64'd1) : minstret_q;

    if (write_en) begin
      case (addr_i)
        A_MSTATUS: begin
          mstatus_mie_d  = new_val[3];
          mstatus_mpie_d = new_val[7];
        end
        A_MIE:       mie_d      = new_val & MIE_MASK;
        A_MTVEC:     mtvec_d    = new_val & ALIGN4;
        A_MSCRATCH:  mscratch_d = new_val;
        A_MEPC:      mepc_d     = new_val & ALIGN4;
        A_MCAUSE:    mcause_d   = new_val;
        // A counter write replaces one half and freezes the whole counter for that cycle.
        A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], new_val};
        A_MCYCLEH:   mcycle_d   = {new_val, mcycle_q[31:0]};
        A_MINSTRET:  minstret_d = {minstret_q[63:32], new_val};
        A_MINSTRETH: minstret_d = {new_val, minstret_q[31:0]};
        default: ;
      endcase
    end

    if (trap_i) begin
      mepc_d         = pc_i & ALIGN4;
      mcause_d       = mcause_i;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'h0;
      mtvec_q        <= MTVEC_RST;
      mscratch_q     <= 32'h0;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      mcycle_q       <= 64'h0;
      minstret_q     <= 64'h0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

  assign rd_o          = old_val;
  assign illegal_o     = illegal;
  assign mie_o         = mie_q;
  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign mcause_o      = mcause_q;
  assign mstatus_mie_o = mstatus_mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: hand-computed expectations for CSR ops, traps, mret,
// counter carry, illegal accesses and reset.
module tb_csr_file;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [2:0]  op_i;
  logic [11:0] addr_i;
  logic [31:0] wd_i;
  logic [4:0]  zimm_i;
  logic [31:0] pc_i;
  logic        trap_i;
  logic [31:0] mcause_i;
  logic        mret_i;
  logic        instret_i;
  logic [31:0] rd_o;
  logic        illegal_o;
  logic [31:0] mie_o;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic [31:0] mcause_o;
  logic        mstatus_mie_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  csr_file #(
    .MTVEC_RESET(32'h0000_1003),
    .HART_ID    (32'h0000_0005),
    .COUNTERS_EN(1'b1)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .op_i         (op_i),
    .addr_i       (addr_i),
    .wd_i         (wd_i),
    .zimm_i       (zimm_i),
    .pc_i         (pc_i),
    .trap_i       (trap_i),
    .mcause_i     (mcause_i),
    .mret_i       (mret_i),
    .instret_i    (instret_i),
    .rd_o         (rd_o),
    .illegal_o    (illegal_o),
    .mie_o        (mie_o),
    .mtvec_o      (mtvec_o),
    .mepc_o       (mepc_o),
    .mcause_o     (mcause_o),
    .mstatus_mie_o(mstatus_mie_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then return all transaction inputs to idle.
  task automatic tick;
    @(posedge clk_i);
    #1;
    op_i      = 3'b000;
    addr_i    = 12'h0;
    wd_i      = 32'h0;
    zimm_i    = 5'h0;
    trap_i    = 1'b0;
    pc_i      = 32'h0;
    mcause_i  = 32'h0;
    mret_i    = 1'b0;
    instret_i = 1'b0;
  endtask

  task automatic csr_op(input logic [2:0] o, input logic [11:0] a, input logic [31:0] wd,
                        input logic [4:0] z);
    op_i   = o;
    addr_i = a;
    wd_i   = wd;
    zimm_i = z;
    #1;
    $display("txn op=%b addr=%03h wd=%08h zimm=%0d -> rd=%08h illegal=%0b",
             o, a, wd, z, rd_o, illegal_o);
  endtask

  // Non-writing read (RSI with zimm=0).
  task automatic peek(input logic [11:0] a, input logic [31:0] exp, input string tag);
    csr_op(3'b110, a, 32'h0, 5'd0);
    check_eq(tag, rd_o, exp);
    check_eq({tag, "_illegal"}, {31'b0, illegal_o}, 32'h0);
  endtask

  initial begin
    rst_i = 1'b1; op_i = 3'b000; addr_i = 12'h0; wd_i = 32'h0; zimm_i = 5'h0;
    pc_i = 32'h0; trap_i = 1'b0; mcause_i = 32'h0; mret_i = 1'b0; instret_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;

    check_eq("rst_mie", mie_o, 32'h0);
    check_eq("rst_mepc", mepc_o, 32'h0);
    check_eq("rst_mcause", mcause_o, 32'h0);
    check_eq("rst_mstatus_mie", {31'b0, mstatus_mie_o}, 32'h0);
    check_eq("rst_mtvec", mtvec_o, 32'h0000_1000);

    peek(12'hF14, 32'h5, "mhartid");
    csr_op(3'b010, 12'hF14, 32'h0, 5'd0);
    check_eq("rs0_ro_legal", {31'b0, illegal_o}, 32'h0);
    csr_op(3'b001, 12'hF14, 32'h1, 5'd0);
    check_eq("rw_hartid_illegal", {31'b0, illegal_o}, 32'h1);
    tick();
    peek(12'hF14, 32'h5, "mhartid_kept");
    csr_op(3'b100, 12'h7C0, 32'h1, 5'd0);
    check_eq("op100_none", {31'b0, illegal_o}, 32'h0);
    tick();

    // mtvec read-old / write-new with low bits masked
    csr_op(3'b001, 12'h305, 32'h8000_0103, 5'd0);
    check_eq("mtvec_rd_old", rd_o, 32'h0000_1000);
    tick();
    check_eq("mtvec_new", mtvec_o, 32'h8000_0100);

    // Enable MIE, trap, mret
    csr_op(3'b110, 12'h300, 32'h0, 5'd8);
    check_eq("mstatus_rd_reset", rd_o, 32'h0000_1800);
    tick();
    check_eq("mie_set", {31'b0, mstatus_mie_o}, 32'h1);
    peek(12'h300, 32'h0000_1808, "mstatus_after_rsi");
    tick();
    trap_i = 1'b1; pc_i = 32'h0000_1006; mcause_i = 32'h8000_000B;
    tick();
    check_eq("trap_mie", {31'b0, mstatus_mie_o}, 32'h0);
    check_eq("trap_mepc", mepc_o, 32'h0000_1004);
    check_eq("trap_mcause", mcause_o, 32'h8000_000B);
    peek(12'h300, 32'h0000_1880, "trap_mstatus");
    tick();
    mret_i = 1'b1;
    tick();
    check_eq("mret_mie", {31'b0, mstatus_mie_o}, 32'h1);
    peek(12'h300, 32'h0000_1888, "mret_mstatus");
    tick();

    // Trap beats CSR write to mepc
    csr_op(3'b001, 12'h341, 32'h55, 5'd0);
    trap_i = 1'b1; pc_i = 32'h0000_2000; mcause_i = 32'h2;
    tick();
    check_eq("trapw_mepc", mepc_o, 32'h0000_2000);
    check_eq("trapw_mcause", mcause_o, 32'h2);
    peek(12'h300, 32'h0000_1880, "trapw_mstatus");
    tick();
    // Trap beats mret
    trap_i = 1'b1; pc_i = 32'h0000_3008; mcause_i = 32'h7; mret_i = 1'b1;
    tick();
    check_eq("trapmret_mie", {31'b0, mstatus_mie_o}, 32'h0);
    check_eq("trapmret_mepc", mepc_o, 32'h0000_3008);
    peek(12'h300, 32'h0000_1800, "trapmret_mstatus");
    tick();
    // Unrelated CSR write survives a trap
    csr_op(3'b001, 12'h340, 32'hA5A5_0001, 5'd0);
    trap_i = 1'b1; pc_i = 32'h0000_4002; mcause_i = 32'h3;
    tick();
    peek(12'h340, 32'hA5A5_0001, "trap_mscratch");
    check_eq("trap_mepc_align", mepc_o, 32'h0000_4000);
    tick();
    // mret beats mstatus write: MIE <= MPIE(0), MPIE <= 1
    csr_op(3'b001, 12'h300, 32'h8, 5'd0);
    mret_i = 1'b1;
    tick();
    check_eq("mretw_mie", {31'b0, mstatus_mie_o}, 32'h0);
    peek(12'h300, 32'h0000_1880, "mretw_mstatus");
    tick();

    // mie mask
    csr_op(3'b001, 12'h304, 32'hFFFF_FFFF, 5'd0);
    tick();
    check_eq("mie_mask", mie_o, 32'h0000_0888);
    csr_op(3'b011, 12'h304, 32'h8, 5'd0);
    check_eq("mie_rc_old", rd_o, 32'h0000_0888);
    tick();
    check_eq("mie_rc", mie_o, 32'h0000_0880);

    // mcycle carry
    csr_op(3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd0);
    tick();
    csr_op(3'b001, 12'hB80, 32'h0, 5'd0);
    tick();
    peek(12'hB00, 32'hFFFF_FFFF, "mcycle_pre");
    peek(12'hB80, 32'h0, "mcycleh_pre");
    tick();
    peek(12'hB00, 32'h0, "mcycle_wrap");
    peek(12'hB80, 32'h1, "mcycleh_carry");
    peek(12'hC00, 32'h0, "cycle_alias");
    peek(12'hC80, 32'h1, "cycleh_alias");
    csr_op(3'b001, 12'hC00, 32'h1234, 5'd0);
    check_eq("rw_cycle_illegal", {31'b0, illegal_o}, 32'h1);
    tick();
    peek(12'hB00, 32'h1, "cycle_no_write");
    peek(12'hB80, 32'h1, "cycleh_hold");
    csr_op(3'b001, 12'h7C0, 32'h5, 5'd0);
    check_eq("unimpl_illegal", {31'b0, illegal_o}, 32'h1);
    check_eq("unimpl_rd", rd_o, 32'h0);
    tick();

    // minstret carry
    csr_op(3'b001, 12'hB02, 32'hFFFF_FFFE, 5'd0);
    instret_i = 1'b1;
    tick();
    peek(12'hB02, 32'hFFFF_FFFE, "minstret_wr");
    instret_i = 1'b1;
    tick();
    tick();
    peek(12'hB02, 32'hFFFF_FFFF, "minstret_hold");
    instret_i = 1'b1;
    tick();
    peek(12'hB02, 32'h0, "minstret_wrap");
    peek(12'hB82, 32'h1, "minstreth_carry");
    peek(12'hC82, 32'h1, "instreth_alias");
    tick();

    // Reset mid-operation with a trap pending
    csr_op(3'b110, 12'h300, 32'h0, 5'd8);
    tick();
    check_eq("pre_rst_mie", {31'b0, mstatus_mie_o}, 32'h1);
    csr_op(3'b001, 12'h304, 32'h8, 5'd0);
    rst_i = 1'b1; trap_i = 1'b1; pc_i = 32'h0000_8000; mcause_i = 32'h9;
    tick();
    rst_i = 1'b0;
    check_eq("rst2_mie", mie_o, 32'h0);
    check_eq("rst2_mepc", mepc_o, 32'h0);
    check_eq("rst2_mcause", mcause_o, 32'h0);
    check_eq("rst2_mstatus_mie", {31'b0, mstatus_mie_o}, 32'h0);
    check_eq("rst2_mtvec", mtvec_o, 32'h0000_1000);
    peek(12'hB00, 32'h0, "rst2_mcycle");
    peek(12'hB80, 32'h0, "rst2_mcycleh");
    peek(12'hB02, 32'h0, "rst2_minstret");
    tick();
    peek(12'hB00, 32'h1, "rst2_mcycle_run");
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- MTVEC_RESET  32'h0000_0000  mtvec value after reset; bits [1:0] forced 0.
- HART_ID  0  value returned by mhartid (0xF14).
- COUNTERS_EN  1  1 = mcycle/minstret implemented; 0 = those addresses illegal.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- op_i  in  3  CSR op, funct3 encoding: 000 none, 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 100 treated as none.
- addr_i  in  12  CSR address.
- wd_i  in  32  rs1 operand for register ops.
- zimm_i  in  5  immediate operand for I ops, zero-extended.
- pc_i  in  32  PC of trapping instruction.
- trap_i  in  1  trap entry this cycle.
- mcause_i  in  32  cause for trap entry.
- mret_i  in  1  mret retiring this cycle.
- instret_i  in  1  one instruction retired this cycle.
- rd_o  out  32  old CSR value, combinational from addr_i.
- illegal_o  out  1  combinational; op_i active and access illegal.
- mie_o  out  32  mie register.
- mtvec_o  out  32  mtvec register.
- mepc_o  out  32  mepc register.
- mcause_o  out  32  mcause register.
- mstatus_mie_o  out  1  global interrupt enable, mstatus.MIE.

Function
REQ-003 Implemented CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, cycle/cycleh 0xC00/0xC80, instret/instreth 0xC02/0xC82, mhartid 0xF14.
REQ-004 rd_o returns the pre-write value of addr_i the same cycle; 0 for unimplemented addresses.
REQ-005 Operand: wd_i when op_i[2]=0, else {27'b0, zimm_i}.
REQ-006 New value: RW = operand; RS = old | operand; RC = old & ~operand; applied on the next rising edge.
REQ-007 RS/RC/RSI/RCI with operand 0 perform no write; a read-only address then is not illegal.
REQ-008 illegal_o = 1 when op_i is active and addr_i is unimplemented, or a write is attempted to 0xC00-0xC82 or 0xF14, or COUNTERS_EN=0 and addr_i is a counter address; no state changes from an illegal access.
REQ-009 Writable masks: mstatus bits 3 (MIE) and 7 (MPIE); mstatus[12:11] (MPP) reads 2'b11; other bits read 0. mie bits 3, 7, 11 only. mtvec and mepc bits [1:0] read 0.
REQ-010 Trap entry (trap_i=1): mepc <= {pc_i[31:2],2'b00}; mcause <= mcause_i; MPIE <= MIE; MIE <= 0.
REQ-011 mret (mret_i=1, trap_i=0): MIE <= MPIE; MPIE <= 1.
REQ-012 Priority within one cycle: trap_i > mret_i > CSR write; a lower-priority update to a field touched by a higher one is dropped; writes to other CSRs the same cycle still take effect.
REQ-013 mcycle: 64-bit counter, +1 every cycle out of reset; wraps 2^64-1 -> 0.
REQ-014 minstret: 64-bit counter, +1 when instret_i=1; wraps likewise.
REQ-015 A CSR write to either half of a counter replaces that half with the written value and suppresses the increment that cycle; the other half holds.
REQ-016 Carry from the low into the high half is applied in the same cycle as the low-half wrap.

Reset
REQ-017 When rst_i=1 at a rising edge: all registers 0, mtvec = MTVEC_RESET & ~3, counters 0; rst_i overrides trap_i, mret_i and writes in the same cycle.
REQ-018 Outputs after reset: mie_o 0, mepc_o 0, mcause_o 0, mstatus_mie_o 0, mtvec_o MTVEC_RESET & ~3.

Verification
REQ-019 RW 0x305 with wd=0x8000_0103 -> rd_o returns old value that cycle; mtvec_o=0x8000_0100 next cycle.
REQ-020 mstatus RSI zimm=8, then trap_i with pc=0x1006, mcause=0x8000_000B -> MIE=0, MPIE=1, mepc=0x1004; then mret -> MIE=1.
REQ-021 trap_i and RW 0x341 (wd=0x55) same cycle -> mepc from pc_i; mret_i with trap_i -> trap behaviour only.
REQ-022 Write mcycle=0xFFFF_FFFF, mcycleh=0 -> two cycles later mcycleh=1, mcycle=0x0000_0000.
REQ-023 RW to 0xC00 or 0x7C0 -> illegal_o=1, no state change; RS 0xC00 with zimm=0 -> illegal_o=0, rd_o=cycle.
REQ-024 rst_i asserted mid-operation with trap_i=1 -> all REQ-018 values next cycle; counters restart from 0.
